// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, requester IDs, arbiter state encoding and
//               small id/one-hot helpers for the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int NUM_REQ = 3;

    localparam logic [1:0] REQ_FETCH = 2'd0;
    localparam logic [1:0] REQ_DATA  = 2'd1;
    localparam logic [1:0] REQ_LOAD  = 2'd2;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE    = 2'd0;
    localparam arb_state_t ACCESS  = 2'd1;
    localparam arb_state_t RESPOND = 2'd2;

    // Round-robin successor, wrapping the last requester back to fetch.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p >= REQ_LOAD) ? REQ_FETCH : p + 2'd1;
    endfunction

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [1:0] id);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        case (id)
            REQ_FETCH: oh = 3'b001;
            REQ_DATA:  oh = 3'b010;
            REQ_LOAD:  oh = 3'b100;
            default:   oh = '0;
        endcase
        return oh;
    endfunction

    function automatic logic [1:0] onehot_to_id(input logic [NUM_REQ-1:0] oh);
        logic [1:0] id;
        case (oh)
            3'b010:  id = REQ_DATA;
            3'b100:  id = REQ_LOAD;
            default: id = REQ_FETCH;
        endcase
        return id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first set request at or
//               after the pointer (wrapping) wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import cpu_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic               valid_o
);

    always_comb begin
        logic [1:0] w_cand;
        win_o   = '0;
        valid_o = 1'b0;
        // An out-of-range pointer restarts the search at fetch.
        w_cand  = (ptr_i > REQ_LOAD) ? REQ_FETCH : ptr_i;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!valid_o && req_i[w_cand]) begin
                win_o   = id_to_onehot(w_cand);
                valid_o = 1'b1;
            end
            w_cand = next_ptr(w_cand);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Three-requester round-robin arbiter in front of a single-port
//               synchronous memory; one access per two cycles back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic [cpu_pkg::NUM_REQ-1:0]   req,
    input  logic [cpu_pkg::NUM_REQ-1:0]   we,
    input  logic [3*ADDR_W-1:0]           addr,
    input  logic [3*DATA_W-1:0]           wdata,
    output logic [cpu_pkg::NUM_REQ-1:0]   gnt,
    output logic [cpu_pkg::NUM_REQ-1:0]   ack,
    output logic [DATA_W-1:0]             rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy
);

    cpu_pkg::arb_state_t state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          id_q, id_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [cpu_pkg::NUM_REQ-1:0] w_pick_win;
    logic                        w_pick_valid;
    logic [1:0]                  w_pick_ptr;
    logic                        w_sel_we;
    logic [ADDR_W-1:0]           w_sel_addr;
    logic [DATA_W-1:0]           w_sel_wdata;
    logic                        w_in_access;
    logic                        w_in_respond;

    assign w_in_access  = (state_q == cpu_pkg::ACCESS);
    assign w_in_respond = (state_q == cpu_pkg::RESPOND);

    // Arbitrating in RESPOND already uses the pointer past the current
    // winner, so a requester re-requesting in its ack cycle yields.
    assign w_pick_ptr = w_in_respond ? cpu_pkg::next_ptr(id_q) : ptr_q;

    rr_pick u_rr_pick (
        .req_i   (req),
        .ptr_i   (w_pick_ptr),
        .win_o   (w_pick_win),
        .valid_o (w_pick_valid)
    );

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < cpu_pkg::NUM_REQ; i++) begin
            if (w_pick_win[i]) begin
                w_sel_we    = we[i];
                w_sel_addr  = addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        logic w_load;
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        w_load  = 1'b0;
        case (state_q)
            cpu_pkg::IDLE: begin
                if (w_pick_valid) begin
                    w_load  = 1'b1;
                    state_d = cpu_pkg::ACCESS;
                end
            end
            cpu_pkg::ACCESS: begin
                state_d = cpu_pkg::RESPOND;
            end
            cpu_pkg::RESPOND: begin
                ptr_d = cpu_pkg::next_ptr(id_q);
                if (!we_q) begin
                    rdata_d = mem_rdata;
                end
                if (w_pick_valid) begin
                    w_load  = 1'b1;
                    state_d = cpu_pkg::ACCESS;
                end else begin
                    state_d = cpu_pkg::IDLE;
                end
            end
            default: begin
                state_d = cpu_pkg::IDLE;
            end
        endcase
        if (w_load) begin
            id_d    = cpu_pkg::onehot_to_id(w_pick_win);
            we_d    = w_sel_we;
            addr_d  = w_sel_addr;
            wdata_d = w_sel_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= cpu_pkg::IDLE;
            ptr_q   <= cpu_pkg::REQ_FETCH;
            id_q    <= cpu_pkg::REQ_FETCH;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign gnt       = w_in_access  ? cpu_pkg::id_to_onehot(id_q) : '0;
    assign ack       = w_in_respond ? cpu_pkg::id_to_onehot(id_q) : '0;
    assign mem_en    = w_in_access;
    assign mem_we    = w_in_access & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = w_in_access | w_in_respond;
    // Read data is presented combinationally in the ack cycle, then held.
    assign rdata     = (w_in_respond && !we_q) ? mem_rdata : rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a small
//               synchronous memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;

    logic            CLK = 1'b0;
    logic            Reset;
    logic [2:0]      req;
    logic [2:0]      we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt;
    logic [2:0]      ack;
    logic [DW-1:0]   rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            busy;
    logic            mem_load;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [0:1023];

    logic [2:0] exp_gnt [8] = '{3'b001, 3'b000, 3'b010, 3'b000,
                                3'b100, 3'b000, 3'b001, 3'b000};
    logic [2:0] exp_ack [8] = '{3'b000, 3'b001, 3'b000, 3'b010,
                                3'b000, 3'b100, 3'b000, 3'b001};

    always #5 CLK = ~CLK;

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Synchronous single-port memory, read data one cycle after mem_en.
    always @(posedge CLK) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= '0;
            end
            mem[64]   <= 16'hBEEF;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[9:0]] <= mem_wdata;
            end
            mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // One-hot grant/ack invariant, sampled mid-cycle.
    always @(negedge CLK) begin
        if (!Reset) begin
            checks++;
            assert ($onehot0(gnt) && $onehot0(ack)) else begin
                failures++;
                $error("FAIL onehot observed gnt=%0b ack=%0b expected at most one bit each", gnt, ack);
            end
        end
    end

    initial begin
        Reset    = 1'b1;
        mem_load = 1'b1;
        req      = '0;
        we       = '0;
        addr     = '0;
        wdata    = '0;
        repeat (2) tick;
        check("rst_gnt",    32'(gnt),    32'(3'b000));
        check("rst_ack",    32'(ack),    32'(3'b000));
        check("rst_mem_en", 32'(mem_en), 32'(1'b0));
        check("rst_mem_we", 32'(mem_we), 32'(1'b0));
        check("rst_busy",   32'(busy),   32'(1'b0));
        check("rst_rdata",  32'(rdata),  32'(16'h0000));
        Reset    = 1'b0;
        mem_load = 1'b0;

        // Single read by fetch
        addr[0 +: AW] = 16'h0040;
        req = 3'b001;
        tick;
        check("rd_gnt",      32'(gnt),      32'(3'b001));
        check("rd_mem_en",   32'(mem_en),   32'(1'b1));
        check("rd_mem_we",   32'(mem_we),   32'(1'b0));
        check("rd_mem_addr", 32'(mem_addr), 32'(16'h0040));
        check("rd_busy",     32'(busy),     32'(1'b1));
        tick;
        check("rd_ack",      32'(ack),      32'(3'b001));
        check("rd_gnt_low",  32'(gnt),      32'(3'b000));
        check("rd_rdata",    32'(rdata),    32'(16'hBEEF));
        req = 3'b000;
        tick;
        check("rd_idle_busy", 32'(busy),  32'(1'b0));
        check("rd_idle_ack",  32'(ack),   32'(3'b000));
        check("rd_hold",      32'(rdata), 32'(16'hBEEF));

        // Write by control-unit data port
        addr[AW +: AW]  = 16'h0100;
        wdata[DW +: DW] = 16'h1234;
        we  = 3'b010;
        req = 3'b010;
        tick;
        check("wr_gnt",       32'(gnt),       32'(3'b010));
        check("wr_mem_we",    32'(mem_we),    32'(1'b1));
        check("wr_mem_wdata", 32'(mem_wdata), 32'(16'h1234));
        check("wr_mem_addr",  32'(mem_addr),  32'(16'h0100));
        tick;
        check("wr_ack",       32'(ack),       32'(3'b010));
        check("wr_rdata_hold", 32'(rdata),    32'(16'hBEEF));
        req = 3'b000;
        we  = 3'b000;
        tick;

        // Read-back of the written word
        req = 3'b010;
        tick;
        check("rb_gnt",    32'(gnt),    32'(3'b010));
        check("rb_mem_we", 32'(mem_we), 32'(1'b0));
        tick;
        check("rb_ack",    32'(ack),    32'(3'b010));
        check("rb_rdata",  32'(rdata),  32'(16'h1234));
        req = 3'b000;
        tick;

        // Pointer now at loader: fetch wins by wrapping, then data back-to-back
        req = 3'b011;
        tick;
        check("wrap_gnt0",  32'(gnt),      32'(3'b001));
        check("wrap_addr0", 32'(mem_addr), 32'(16'h0040));
        tick;
        check("wrap_ack0",  32'(ack),      32'(3'b001));
        check("wrap_rd0",   32'(rdata),    32'(16'hBEEF));
        req = 3'b010;
        tick;
        check("wrap_gnt1",  32'(gnt),      32'(3'b010));
        tick;
        check("wrap_ack1",  32'(ack),      32'(3'b010));
        check("wrap_rd1",   32'(rdata),    32'(16'h1234));
        req = 3'b000;
        tick;

        // Loader raises req mid-access and drops it before it is sampled
        req = 3'b001;
        tick;
        check("wd_gnt", 32'(gnt), 32'(3'b001));
        req = 3'b101;
        tick;
        check("wd_ack", 32'(ack), 32'(3'b001));
        req = 3'b000;
        tick;
        check("wd_nogrant",  32'(gnt),  32'(3'b000));
        check("wd_not_busy", 32'(busy), 32'(1'b0));
        tick;
        check("wd_nogrant2", 32'(gnt),  32'(3'b000));

        // Pointer at data: loader first, then fetch, then loader again
        req = 3'b101;
        tick;
        check("ld_gnt",       32'(gnt), 32'(3'b100));
        tick;
        check("ld_ack",       32'(ack), 32'(3'b100));
        tick;
        check("ld_fetch_gnt", 32'(gnt), 32'(3'b001));
        tick;
        check("ld_fetch_ack", 32'(ack), 32'(3'b001));
        tick;
        check("ld_gnt2",      32'(gnt), 32'(3'b100));
        tick;
        check("ld_ack2",      32'(ack), 32'(3'b100));
        req = 3'b000;
        tick;

        // Full contention from pointer at fetch
        req = 3'b111;
        for (int i = 0; i < 8; i++) begin
            tick;
            check($sformatf("cont_gnt%0d", i), 32'(gnt), 32'(exp_gnt[i]));
            check($sformatf("cont_ack%0d", i), 32'(ack), 32'(exp_ack[i]));
        end
        req = 3'b000;
        tick;

        // Reset during an in-flight access
        req = 3'b010;
        tick;
        check("ra_gnt", 32'(gnt), 32'(3'b010));
        Reset = 1'b1;
        tick;
        check("ra_ack",    32'(ack),    32'(3'b000));
        check("ra_mem_en", 32'(mem_en), 32'(1'b0));
        check("ra_busy",   32'(busy),   32'(1'b0));
        check("ra_gnt0",   32'(gnt),    32'(3'b000));
        Reset = 1'b0;
        req   = 3'b001;
        tick;
        check("ra_next_gnt", 32'(gnt),   32'(3'b001));
        tick;
        check("ra_next_ack", 32'(ack),   32'(3'b001));
        check("ra_next_rd",  32'(rdata), 32'(16'hBEEF));
        req = 3'b000;
        tick;
        check("ra_final_idle", 32'(busy), 32'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, data word width.
REQ-002 Parameter ADDR_W, default 16, word-address width.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 req  input  3  access request per requester; bit0 fetch, bit1 control-unit data, bit2 loader.
REQ-006 we  input  3  per-requester write enable (1 = write, 0 = read).
REQ-007 addr  input  3*ADDR_W  per-requester address, requester i in slice i.
REQ-008 wdata  input  3*DATA_W  per-requester write data, requester i in slice i.
REQ-009 gnt  output  3  one-hot one-cycle pulse: request accepted, memory cycle issued.
REQ-010 ack  output  3  one-hot one-cycle pulse: access complete.
REQ-011 rdata  output  DATA_W  read data, valid only when ack[i] asserted and we[i] was 0 at grant.
REQ-012 mem_en, mem_we  output  1 each  memory strobe and write enable.
REQ-013 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  memory address and write data.
REQ-014 mem_rdata  input  DATA_W  synchronous memory read data, valid one cycle after mem_en.
REQ-015 busy  output  1  high in ACCESS and RESPOND.

Function
REQ-016 FSM states: IDLE, ACCESS, RESPOND.
REQ-017 IDLE: if any req bit high, select winner, latch id/we/addr/wdata, go to ACCESS; else stay.
REQ-018 ACCESS: mem_en=1, mem_we/mem_addr/mem_wdata from latched values, gnt[winner]=1; next state RESPOND.
REQ-019 RESPOND: ack[winner]=1; rdata=mem_rdata captured for reads; advance round-robin pointer past winner.
REQ-020 RESPOND: if any req pending, arbitrate and go directly to ACCESS; else go to IDLE.
REQ-021 Arbitration: round-robin; search starts at pointer, increments mod 3, wraps 2->0; first set req bit wins.
REQ-022 Latency: req sampled in IDLE at edge t -> gnt cycle t+1 -> ack cycle t+2; back-to-back throughput one access per 2 cycles.
REQ-023 Handshake: requester holds req/we/addr/wdata stable until ack; the requester deasserts req in the ack cycle unless it has a new access.
REQ-024 A requester holding req in the ack cycle is treated as a new request; it loses the tie to other pending requesters, since the pointer has moved past it.
REQ-025 Dropping req before gnt withdraws the request with no effect; changes to req after gnt do not cancel the access.
REQ-026 Outside ACCESS: mem_en=0, mem_we=0, gnt=0; outside RESPOND: ack=0.
REQ-027 rdata holds its last captured value until the next read completes.
REQ-028 At most one gnt bit and one ack bit are high in any cycle.

Reset
REQ-029 Reset high at an edge: state=IDLE, pointer=0 (fetch first), latched id=0, rdata=0; all outputs low on the next cycle.
REQ-030 Reset in ACCESS or RESPOND abandons the in-flight access: no ack is issued. A write already strobed to memory is not undone.
REQ-031 Reset has priority over all other inputs.

Structure
REQ-032 Shared package cpu_pkg holds DATA_W, ADDR_W, NUM_REQ=3, requester IDs REQ_FETCH=0/REQ_DATA=1/REQ_LOAD=2, and the arb_state_t encoding IDLE=0/ACCESS=1/RESPOND=2.
REQ-033 A single combinational sub-module rr_pick selects the winner. Inputs: req, pointer. Outputs: one-hot winner and a valid flag.

Verification
REQ-034 Single read: req=001, addr0=0x0040, mem holds 0xBEEF -> gnt=001 at t+1 with mem_addr=0x0040, mem_we=0; ack=001 with rdata=0xBEEF at t+2.
REQ-035 Write: req=010, we=010, addr1=0x0100, wdata1=0x1234 -> gnt=010 with mem_we=1, mem_wdata=0x1234 at t+1; ack=010 at t+2; read-back returns 0x1234.
REQ-036 Contention: req=111 held from pointer=0 -> grants in order 001, 010, 100, 001; gnt is 2 cycles apart; never two bits high.
REQ-037 Withdrawal: req=100 pulsed 0 cycles before IDLE sampling -> no gnt; with req=101 held, fetch wins after pointer passes the loader.
REQ-038 Reset in ACCESS: Reset=1 while gnt=010 -> next cycle state IDLE, ack=000, mem_en=0, busy=0; the next req=001 is granted at t+1.
REQ-039 Wrap: pointer=2, req=011 -> gnt=001 (wrap 2->0), then gnt=010.
